// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   muldiv_op_t : M-extension operation, encoded as the instruction funct3.
//   is_muldiv() : decode helper, true for OP-opcode instructions with
//                 funct7 = 0000001 (the M-extension group).
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic is_muldiv(input logic [31:0] instr);
        return (instr[6:0] == OPCODE_OP) && (instr[31:25] == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/muldiv_divider_step.sv
// muldiv_divider_step: one combinational radix-2 restoring-division step
// on unsigned magnitudes.
//   rem_in  : partial remainder so far
//   quo_in  : dividend bits not yet consumed (MSB first) / quotient so far
//   divisor : divisor magnitude
//   rem_out : updated partial remainder
//   quo_out : quo_in shifted left with the new quotient bit in the LSB
module muldiv_divider_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] partial;
    logic          fits;

    // The partial remainder stays below the divisor, so shifting in one
    // dividend bit needs only one extra bit of headroom.
    assign partial = {rem_in, quo_in[XLEN-1]};
    assign fits    = partial >= {1'b0, divisor};
    assign rem_out = fits ? XLEN'(partial - {1'b0, divisor}) : partial[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
//   clk, reset     : clock; synchronous active-high reset
//   start          : request, held by EX while an M-op occupies EX
//   flush          : synchronous abort, wins over start
//   op             : muldiv_op_t (funct3)
//   left_operand   : rs1 value;  right_operand : rs2 value
//   busy           : high while iterating (CALC)
//   done           : one-cycle pulse, result valid
//   result         : registered result, held until the next done
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle 33x33
// signed multiplier instead of the 32-step shift-add loop.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] left_operand,
    input  logic [XLEN-1:0] right_operand,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int CNT_W = 6;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] count_q;
    muldiv_op_t      op_q;
    logic            lhs_neg_q, rhs_neg_q;
    logic [XLEN-1:0] a_q;      // multiplicand / divisor magnitude
    logic [XLEN-1:0] hi_q;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q;     // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0] result_q;

    // ---------------- operand decode at acceptance ----------------
    logic            lhs_signed, rhs_signed, lhs_neg, rhs_neg;
    logic [XLEN-1:0] lhs_mag, rhs_mag;
    logic            div_zero, div_ovf, short_path;
    logic [XLEN-1:0] special_result, short_result;

    assign lhs_signed = (op != MD_MULHU) && (op != MD_DIVU) && (op != MD_REMU);
    assign rhs_signed = lhs_signed && (op != MD_MULHSU);
    assign lhs_neg    = lhs_signed && left_operand[XLEN-1];
    assign rhs_neg    = rhs_signed && right_operand[XLEN-1];
    assign lhs_mag    = lhs_neg ? -left_operand  : left_operand;
    assign rhs_mag    = rhs_neg ? -right_operand : right_operand;

    // Divide-by-zero and signed overflow bypass the iteration.
    // op[2] marks divide ops, op[1] selects remainder within them.
    assign div_zero = op[2] && (right_operand == '0);
    assign div_ovf  = ((op == MD_DIV) || (op == MD_REM))
                   && (left_operand == {1'b1, {(XLEN-1){1'b0}}})
                   && (right_operand == '1);
    assign special_result = op[1] ? (div_ovf ? '0 : left_operand)
                                  : (div_zero ? '1 : left_operand);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_lhs, fast_rhs;
    logic signed [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]          fast_result;

    assign fast_lhs    = {lhs_signed && left_operand[XLEN-1], left_operand};
    assign fast_rhs    = {rhs_signed && right_operand[XLEN-1], right_operand};
    assign fast_prod   = (2*XLEN)'(fast_lhs) * (2*XLEN)'(fast_rhs);
    assign fast_result = (op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    assign short_path   = div_zero || div_ovf || !op[2];
    assign short_result = op[2] ? special_result : fast_result;
`else
    assign short_path   = div_zero || div_ovf;
    assign short_result = special_result;
`endif

    // ---------------- iteration step ----------------
    logic [XLEN-1:0] div_rem, div_quo, step_hi, step_lo;
    logic [XLEN:0]   mul_sum;

    muldiv_divider_step #(.XLEN(XLEN)) u_step (
        .rem_in  (hi_q),
        .quo_in  (lo_q),
        .divisor (a_q),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the 65-bit {carry, hi, lo} right by one.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign step_hi = op_q[2] ? div_rem : mul_sum[XLEN:1];
    assign step_lo = op_q[2] ? div_quo : {mul_sum[0], lo_q[XLEN-1:1]};

    // ---------------- sign correction on the final step ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

    assign prod_fix = (lhs_neg_q ^ rhs_neg_q) ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign quo_fix  = (lhs_neg_q ^ rhs_neg_q) ? -step_lo : step_lo;
    assign rem_fix  = lhs_neg_q ? -step_hi : step_hi;

    always_comb begin
        final_result = quo_fix;
        case (op_q)
            MD_MUL:                      final_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
            MD_REM, MD_REMU:             final_result = rem_fix;
            default:                     final_result = quo_fix;
        endcase
    end

    // ---------------- FSM ----------------
    logic accept, last_step;

    assign accept    = (state_q == IDLE) && start && !flush;
    assign last_step = (state_q == CALC) && (count_q == CNT_W'(XLEN-1));

    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = short_path ? DONE : CALC;
            CALC: if (last_step) state_d = DONE;
            DONE: state_d = IDLE;   // a still-held start is ignored here
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            op_q      <= MD_MUL;
            lhs_neg_q <= 1'b0;
            rhs_neg_q <= 1'b0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
        end else if (accept) begin
            count_q   <= '0;
            op_q      <= op;
            lhs_neg_q <= lhs_neg;
            rhs_neg_q <= rhs_neg;
            a_q       <= rhs_mag;
            hi_q      <= '0;
            lo_q      <= lhs_mag;
            if (short_path) result_q <= short_result;
        end else if ((state_q == CALC) && !flush) begin
            count_q <= count_q + 1'b1;
            hi_q    <= step_hi;
            lo_q    <= step_lo;
            if (last_step) result_q <= final_result;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Cycle T+n is the cycle after the n-th rising edge following the edge T
// that samples start; outputs are sampled on the falling edge.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 32;
`endif

    logic        clk = 1'b0;
    logic        reset, start, flush;
    muldiv_op_t  op;
    logic [31:0] left_operand, right_operand, result;
    logic        busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .flush         (flush),
        .op            (op),
        .left_operand  (left_operand),
        .right_operand (right_operand),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; counts busy cycles. Operands are scrambled in
    // cycle T+2 to show they are only sampled at acceptance. start is dropped
    // in the done cycle unless hold is set.
    task automatic wait_done(input bit hold, output int done_at, output int busy_cnt);
        int n;
        n = 0; done_at = 0; busy_cnt = 0;
        while (done_at == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (done) done_at = n;
            if (n == 2) begin
                left_operand  = ~left_operand;
                right_operand = ~right_operand;
            end
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy, input bit hold);
        int done_at, busy_cnt;
        @(negedge clk);
        op = o; left_operand = a; right_operand = b; start = 1'b1;
        wait_done(hold, done_at, busy_cnt);
        check({tag, " result"}, result, exp_res);
        check({tag, " done cycle"}, done_at, exp_lat);
        check({tag, " busy cycles"}, busy_cnt, exp_busy);
    endtask

    initial begin
        int done_at, busy_cnt, pulses;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = MD_MUL;
        left_operand = '0; right_operand = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 32'h0);

        // multiply
        run_op("MUL 7*-3",     MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, MUL_BUSY, 1'b0);
        run_op("MULH min*min", MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, MUL_BUSY, 1'b0);
        run_op("MULHU max",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, MUL_BUSY, 1'b0);
        run_op("MULHSU -1*max",MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, MUL_BUSY, 1'b0);

        // divide
        run_op("DIV -7/2",     MD_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 32, 1'b0);
        run_op("REM -7/2",     MD_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 32, 1'b0);
        run_op("DIVU 100/7",   MD_DIVU, 32'd100,      32'd7, 32'd14,       33, 32, 1'b0);
        run_op("REMU 100/7",   MD_REMU, 32'd100,      32'd7, 32'd2,        33, 32, 1'b0);

        // flush mid-CALC: no done, busy low in T+11, result kept, restart accepted
        @(negedge clk);
        op = MD_DIVU; left_operand = 32'd1000; right_operand = 32'd10; start = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done) pulses++;
            if (n == 10) flush = 1'b1;
        end
        @(negedge clk);
        check("flush done pulses", pulses, 0);
        check("flush busy T+11", busy, 1'b0);
        check("flush done T+11", done, 1'b0);
        check("flush result kept", result, 32'd2);
        flush = 1'b0; left_operand = 32'd9; right_operand = 32'd3;
        wait_done(1'b0, done_at, busy_cnt);
        check("DIVU 9/3 after flush result", result, 32'd3);
        check("DIVU 9/3 after flush done cycle", done_at, 33);

        // special cases
        run_op("DIV 5/0",      MD_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 1'b0);
        run_op("REMU 5/0",     MD_REMU, 32'd5,        32'd0,        32'd5,        1, 0, 1'b0);
        run_op("DIV overflow", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 1'b0);
        run_op("REM overflow", MD_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 0, 1'b0);

        // start held through DONE: exactly one pulse for the request
        run_op("MUL held", MD_MUL, 32'd3, 32'd5, 32'd15, MUL_LAT, MUL_BUSY, 1'b1);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("held start extra done pulses", pulses, 0);

        // reset asserted mid-CALC
        @(negedge clk);
        op = MD_DIVU; left_operand = 32'd100; right_operand = 32'd7; start = 1'b1;
        repeat (5) @(negedge clk);
        check("mid-CALC busy before reset", busy, 1'b1);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("reset mid-CALC busy", busy, 1'b0);
        check("reset mid-CALC done", done, 1'b0);
        check("reset mid-CALC result", result, 32'h0);
        reset = 1'b0;

        run_op("MULHU after reset", MD_MULHU, 32'h00010000, 32'h00010000, 32'h1, MUL_LAT, MUL_BUSY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
